edge_proc_pipe: RTL and testbench
=================================

// Module: edge_proc_pipe
// PURPOSE
//  Parametrised successor to the two-pixel edge-processing front end. Takes N packed pixels per ZBT word plus
//  per-lane Sobel magnitudes, applies the frame-latched mode (pass / grayscale / threshold edge) and emits the
//  processed word with a forecast ZBT write address and a write strobe, all cycle-aligned by an address delay line.
//  Sits between the Sobel kernel and the ZBT bank-1 write port, beside the vram display forecaster.
// PARAMETERS
//  PIX_PER_WORD  2     pixels packed per ZBT word; power of two, 1..4
//  PIX_W         18    bits per pixel, RGB 6:6:6 (R at MSBs)
//  MAG_W         8     bits per lane of Sobel magnitude
//  LEAD          8     forecast lead in pixels (hcount_f = hcount + LEAD)
//  H_TOTAL       1056  pixels per line incl. blanking
//  V_TOTAL       806   lines per frame incl. blanking
//  H_ACTIVE      1024  visible pixels per line
//  V_ACTIVE      768   visible lines
//  PROC_LAT      8     cycles from forecast to write; >= 1
// PORTS
//  clk           in   1                   pixel clock
//  reset         in   1                   synchronous, active-high
//  hcount        in   11                  current horizontal count
//  vcount        in   10                  current vertical count
//  pix_in        in   PIX_PER_WORD*PIX_W  packed pixels, lane 0 at LSBs
//  mag_in        in   PIX_PER_WORD*MAG_W  Sobel magnitude per lane, aligned with pix_in
//  thresh        in   MAG_W               edge threshold
//  gs_switch     in   1                   request grayscale mode
//  so_switch     in   1                   request Sobel threshold mode (priority over gs_switch)
//  wr_word       out  PIX_PER_WORD*PIX_W  processed word
//  wr_addr       out  ADDR_W              ZBT word address, ADDR_W = 20 - log2(PIX_PER_WORD)
//  wr_en         out  1                   one-cycle write strobe per word
//  edg_sel       out  1                   any lane of the current word is an edge (Sobel mode only)
//  frame_start   out  1                   registered pulse, hcount==0 && vcount==0
//  edge_count    out  20                  edge pixels in last frame (EDGE_STATS_EN only)
// BEHAVIOUR
//  - Reset: all outputs 0, delay line cleared, mode = PASS; edge_count 0.
//  - Forecast (combinational): hcount >= H_TOTAL-LEAD -> hcount_f = hcount-(H_TOTAL-LEAD), vcount_f = vcount+1,
//    wrapping V_TOTAL-1 -> 0; else hcount_f = hcount+LEAD, vcount_f = vcount.
//  - addr_f = {vcount_f[9:0], hcount_f[9:WSH]}, WSH = log2(PIX_PER_WORD).
//  - we_f = (hcount_f < H_ACTIVE) && (vcount_f < V_ACTIVE) && (hcount_f[WSH-1:0] == PIX_PER_WORD-1).
//  - {addr_f, we_f} enter a PROC_LAT-deep shift register; its tail drives wr_addr / wr_en.
//  - Mode latch: {so_switch, gs_switch} sampled only when hcount==0 && vcount==0; no mid-frame mode change.
//    Modes: SOBEL (so=1), GRAY (so=0, gs=1), PASS (otherwise).
//  - Data path, 1 registered stage; pix_in/mag_in arrive PROC_LAT-1 cycles after the hcount they belong to.
//    PASS: lane copied. GRAY: g = (R + 2G + B) >> 2 (8-bit sum, 6-bit result), lane = {g,g,g}.
//    SOBEL: lane = (mag >= thresh) ? all ones : 0; mag == thresh is an edge.
//  - edg_sel = registered OR of lane edge bits in SOBEL, else 0; same cycle as wr_word.
//  - wr_word updates every cycle; consumers use it only when wr_en=1.
//  - Reset mid-frame: delay line flushed, so wr_en stays 0 for PROC_LAT cycles after release; mode stays PASS
//    until the next frame start.
// CONFIGURATION
//  - EDGE_STATS_EN defined: 20-bit counter adds the count of edge lanes on each wr_en cycle in SOBEL mode,
//    saturating at 2^20-1. At frame start it is copied to edge_count and cleared in the same cycle; an edge
//    on that cycle counts toward the new frame.
//  - Undefined: no counter; edge_count tied to 0.
// STRUCTURE
//  - Package edge_pkg: mode enum {PASS, GRAY, SOBEL}, default XGA timing constants, grayscale weight function.
//  - Sub-module pix_addr_forecast: forecast, addr/we generation and PROC_LAT delay line. Data path and mode
//    latch stay in the top.
// TESTING
//  - Reset held 3 cycles mid-line -> all outputs 0; wr_en 0 for 8 cycles after release (PROC_LAT=8).
//  - hcount=1047, vcount=5 -> hcount_f=1055, no write; hcount=1048 -> hcount_f=0, vcount_f=6;
//    hcount=1049, vcount=5 -> addr 0x0C00, wr_en 8 cycles later.
//  - vcount=805, hcount=1050 -> vcount_f wraps to 0; vcount_f >= 768 gives no wr_en for the whole line.
//  - so_switch raised mid-frame -> output stays PASS until hcount=vcount=0, then SOBEL;
//    thresh=0x40, mag lanes {0x40,0x3F} -> lane0 all ones, lane1 0, edg_sel=1.
//  - GRAY, pixel R=63 G=0 B=63 -> g=31, lane = 0x1F7DF.
//  - EDGE_STATS_EN: 1000 edge lanes in frame -> edge_count=1000 one cycle after frame_start;
//    without the macro edge_count stays 0.

Source files
------------

// File: rtl/edge_pkg.sv
// ============================================================================
// Package : edge_pkg
// Desc    : Shared types, default XGA timing and grayscale helper for the
//           edge-processing pipeline.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package edge_pkg;

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        GRAY  = 2'd1,
        SOBEL = 2'd2
    } mode_t;

    localparam int XGA_H_TOTAL  = 1056;
    localparam int XGA_V_TOTAL  = 806;
    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_V_ACTIVE = 768;
    localparam int CH_W         = 6;

    // so_switch wins over gs_switch
    function automatic mode_t select_mode(input logic so, input logic gs);
        if (so)
            return SOBEL;
        else if (gs)
            return GRAY;
        else
            return PASS;
    endfunction

    // (R + 2G + B) >> 2 on an RGB 6:6:6 pixel; the 8-bit sum cannot overflow
    function automatic logic [CH_W-1:0] gray_weight(input logic [3*CH_W-1:0] px);
        logic [CH_W+1:0] sum;
        sum = {2'b00, px[3*CH_W-1:2*CH_W]}
            + {1'b0, px[2*CH_W-1:CH_W], 1'b0}
            + {2'b00, px[CH_W-1:0]};
        return sum[CH_W+1:2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/edge_proc_pipe_forecast.sv
// ============================================================================
// Module : pix_addr_forecast
// Desc   : Forecasts raster position LEAD pixels ahead, builds the ZBT word
//          address / write enable and delays them PROC_LAT cycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pix_addr_forecast
    import edge_pkg::*;
#(
    parameter  int PIX_PER_WORD = 2,
    parameter  int LEAD         = 8,
    parameter  int H_TOTAL      = XGA_H_TOTAL,
    parameter  int V_TOTAL      = XGA_V_TOTAL,
    parameter  int H_ACTIVE     = XGA_H_ACTIVE,
    parameter  int V_ACTIVE     = XGA_V_ACTIVE,
    parameter  int PROC_LAT     = 8,
    localparam int WSH          = $clog2(PIX_PER_WORD),
    localparam int ADDR_W       = 20 - WSH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en
);

    localparam logic [10:0] H_WRAP = 11'(H_TOTAL - LEAD);
    localparam logic [10:0] H_LEAD = 11'(LEAD);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);

    logic              w_wrap;
    logic [10:0]       w_hcount_f;
    logic [9:0]        w_vcount_f;
    logic              w_last_lane;
    logic [ADDR_W-1:0] w_addr_f;
    logic              w_we_f;
    logic [ADDR_W:0]   r_dly [PROC_LAT];

    assign w_wrap     = (hcount >= H_WRAP);
    assign w_hcount_f = w_wrap ? (hcount - H_WRAP) : (hcount + H_LEAD);
    assign w_vcount_f = !w_wrap             ? vcount :
                        (vcount == V_LAST)  ? 10'd0  : (vcount + 10'd1);

    // Only the last pixel of a packed word triggers its write
    generate
        if (WSH == 0) begin : g_single_lane
            assign w_last_lane = 1'b1;
        end else begin : g_multi_lane
            assign w_last_lane = (w_hcount_f[WSH-1:0] == WSH'(PIX_PER_WORD - 1));
        end
    endgenerate

    assign w_addr_f = {w_vcount_f, w_hcount_f[9:WSH]};
    assign w_we_f   = (w_hcount_f < H_ACT) && (w_vcount_f < V_ACT) && w_last_lane;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PROC_LAT; i++)
                r_dly[i] <= '0;
        end else begin
            r_dly[0] <= {w_addr_f, w_we_f};
            for (int i = 1; i < PROC_LAT; i++)
                r_dly[i] <= r_dly[i-1];
        end
    end

    assign {wr_addr, wr_en} = r_dly[PROC_LAT-1];

endmodule

`default_nettype wire

// File: rtl/edge_proc_pipe.sv
// ============================================================================
// Module : edge_proc_pipe
// Desc   : N-pixel-per-word pass / grayscale / Sobel-threshold stage feeding
//          the ZBT write port. Optional macro EDGE_STATS_EN adds a per-frame
//          edge pixel counter on edge_count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module edge_proc_pipe
    import edge_pkg::*;
#(
    parameter  int PIX_PER_WORD = 2,
    parameter  int PIX_W        = 18,
    parameter  int MAG_W        = 8,
    parameter  int LEAD         = 8,
    parameter  int H_TOTAL      = XGA_H_TOTAL,
    parameter  int V_TOTAL      = XGA_V_TOTAL,
    parameter  int H_ACTIVE     = XGA_H_ACTIVE,
    parameter  int V_ACTIVE     = XGA_V_ACTIVE,
    parameter  int PROC_LAT     = 8,
    localparam int ADDR_W       = 20 - $clog2(PIX_PER_WORD)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [10:0]                   hcount,
    input  logic [9:0]                    vcount,
    input  logic [PIX_PER_WORD*PIX_W-1:0] pix_in,
    input  logic [PIX_PER_WORD*MAG_W-1:0] mag_in,
    input  logic [MAG_W-1:0]              thresh,
    input  logic                          gs_switch,
    input  logic                          so_switch,
    output logic [PIX_PER_WORD*PIX_W-1:0] wr_word,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic                          wr_en,
    output logic                          edg_sel,
    output logic                          frame_start,
    output logic [19:0]                   edge_count
);

    mode_t                         r_mode;
    logic                          w_fs;
    logic [PIX_PER_WORD*PIX_W-1:0] w_word;
    logic [PIX_PER_WORD-1:0]       w_edge;
    logic [PIX_PER_WORD*PIX_W-1:0] r_word;
    logic                          r_edg_sel;
    logic                          r_frame_start;

    pix_addr_forecast #(
        .PIX_PER_WORD (PIX_PER_WORD),
        .LEAD         (LEAD),
        .H_TOTAL      (H_TOTAL),
        .V_TOTAL      (V_TOTAL),
        .H_ACTIVE     (H_ACTIVE),
        .V_ACTIVE     (V_ACTIVE),
        .PROC_LAT     (PROC_LAT)
    ) u_forecast (
        .clk     (clk),
        .reset   (reset),
        .hcount  (hcount),
        .vcount  (vcount),
        .wr_addr (wr_addr),
        .wr_en   (wr_en)
    );

    assign w_fs = (hcount == 11'd0) && (vcount == 10'd0);

    // Lane processing; PIX_W is the RGB 6:6:6 width (3*CH_W)
    generate
        for (genvar l = 0; l < PIX_PER_WORD; l++) begin : g_lane
            logic [PIX_W-1:0] w_pix;
            logic [MAG_W-1:0] w_mag;
            logic [CH_W-1:0]  w_gray;

            assign w_pix     = pix_in[l*PIX_W +: PIX_W];
            assign w_mag     = mag_in[l*MAG_W +: MAG_W];
            assign w_gray    = gray_weight(w_pix);
            assign w_edge[l] = (r_mode == SOBEL) && (w_mag >= thresh);
            assign w_word[l*PIX_W +: PIX_W] =
                (r_mode == SOBEL) ? {PIX_W{w_edge[l]}}      :
                (r_mode == GRAY)  ? {w_gray, w_gray, w_gray} : w_pix;
        end
    endgenerate

    // Mode only changes at the top-left pixel so a frame is never mixed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode        <= PASS;
            r_word        <= '0;
            r_edg_sel     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            if (w_fs)
                r_mode <= select_mode(so_switch, gs_switch);
            r_word        <= w_word;
            r_edg_sel     <= |w_edge;
            r_frame_start <= w_fs;
        end
    end

    assign wr_word     = r_word;
    assign edg_sel     = r_edg_sel;
    assign frame_start = r_frame_start;

`ifdef EDGE_STATS_EN
    logic [PIX_PER_WORD-1:0] r_edge_bits;
    logic [2:0]              w_edge_inc;
    logic [20:0]             w_acc_sum;
    logic [19:0]             r_edge_acc;
    logic [19:0]             r_edge_count;

    always_comb begin
        w_edge_inc = '0;
        if (wr_en) begin
            for (int i = 0; i < PIX_PER_WORD; i++)
                w_edge_inc = w_edge_inc + 3'(r_edge_bits[i]);
        end
    end

    // On the frame-start cycle the old total is published and the new frame
    // starts from this cycle's increment
    assign w_acc_sum = {1'b0, (r_frame_start ? 20'd0 : r_edge_acc)} + 21'(w_edge_inc);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge_bits  <= '0;
            r_edge_acc   <= '0;
            r_edge_count <= '0;
        end else begin
            r_edge_bits <= w_edge;
            r_edge_acc  <= w_acc_sum[20] ? 20'hFFFFF : w_acc_sum[19:0];
            if (r_frame_start)
                r_edge_count <= r_edge_acc;
        end
    end

    assign edge_count = r_edge_count;
`else
    assign edge_count = 20'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_edge_proc_pipe.sv
// ============================================================================
// Module : tb_edge_proc_pipe
// Desc   : Directed scoreboard bench for edge_proc_pipe (default XGA, 2 px/word).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_edge_proc_pipe;

    localparam logic [35:0] P_PIX   = {18'h15A3C, 18'h2A5C3};
    localparam logic [35:0] G_PIX   = {18'h0A51E, 18'h3F03F};
    localparam logic [35:0] G_WORD  = {18'h14514, 18'h1F7DF};
`ifdef EDGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [18:0] addr;
        logic [35:0] word;
        logic        edg;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [35:0] pix_in;
    logic [15:0] mag_in;
    logic [7:0]  thresh;
    logic        gs_switch;
    logic        so_switch;
    logic [35:0] wr_word;
    logic [18:0] wr_addr;
    logic        wr_en;
    logic        edg_sel;
    logic        frame_start;
    logic [19:0] edge_count;

    exp_t sb[$];
    int   total     = 0;
    int   bad       = 0;
    int   exp_edges = 0;

    always #5 clk = ~clk;

    edge_proc_pipe #(
        .PIX_PER_WORD (2),
        .PIX_W        (18),
        .MAG_W        (8),
        .LEAD         (8),
        .H_TOTAL      (1056),
        .V_TOTAL      (806),
        .H_ACTIVE     (1024),
        .V_ACTIVE     (768),
        .PROC_LAT     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .pix_in      (pix_in),
        .mag_in      (mag_in),
        .thresh      (thresh),
        .gs_switch   (gs_switch),
        .so_switch   (so_switch),
        .wr_word     (wr_word),
        .wr_addr     (wr_addr),
        .wr_en       (wr_en),
        .edg_sel     (edg_sel),
        .frame_start (frame_start),
        .edge_count  (edge_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_wr_en", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_word", 64'(wr_word), 64'(e.word));
                check("edg_sel", 64'(edg_sel), 64'(e.edg));
            end
        end
    end

    // Each helper is entered on a negedge and returns on the next one
    task automatic wr(input int h, input int v, input logic [18:0] a,
                      input logic [35:0] w, input logic e, input int ne);
        exp_t x;
        hcount = 11'(h);
        vcount = 10'(v);
        x.addr = a;
        x.word = w;
        x.edg  = e;
        sb.push_back(x);
        exp_edges += ne;
        @(negedge clk);
    endtask

    task automatic nw(input int h, input int v);
        hcount = 11'(h);
        vcount = 10'(v);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            nw(100, 780);
    endtask

    task automatic frame_start_seq();
        idle(8);
        nw(0, 0);
        check("frame_start_pulse", 64'(frame_start), 64'd1);
        nw(100, 780);
        check("frame_start_clear", 64'(frame_start), 64'd0);
        check("edge_count", 64'(edge_count), STATS ? 64'(exp_edges) : 64'd0);
        exp_edges = 0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        reset     = 1'b1;
        hcount    = 11'd101;
        vcount    = 10'd5;
        pix_in    = P_PIX;
        mag_in    = 16'h0000;
        thresh    = 8'h40;
        gs_switch = 1'b0;
        so_switch = 1'b0;

        // Reset held 3 cycles mid-line on a position that would write
        repeat (3) @(negedge clk);
        check("rst_wr_en",       64'(wr_en),       64'd0);
        check("rst_wr_addr",     64'(wr_addr),     64'd0);
        check("rst_wr_word",     64'(wr_word),     64'd0);
        check("rst_edg_sel",     64'(edg_sel),     64'd0);
        check("rst_frame_start", 64'(frame_start), 64'd0);
        check("rst_edge_count",  64'(edge_count),  64'd0);
        reset = 1'b0;

        // Writes issued right after release surface only after 8 cycles
        for (int i = 0; i < 8; i++) begin
            wr(101 + 2 * i, 5, 19'h00A36 + 19'(i), P_PIX, 1'b0, 0);
            if (i < 7)
                check("wr_en_post_release", 64'(wr_en), 64'd0);
        end
        idle(8);

        // Horizontal wrap region, PASS data
        nw(1047, 5);
        nw(1048, 5);
        wr(1049, 5, 19'h00C00, P_PIX, 1'b0, 0);
        nw(1050, 5);
        wr(1051, 5, 19'h00C01, P_PIX, 1'b0, 0);
        wr(1015, 5, 19'h00BFF, P_PIX, 1'b0, 0);
        nw(1017, 5);
        nw(1016, 5);

        // Vertical wrap and last active line
        nw(1050, 805);
        wr(1051, 805, 19'h00001, P_PIX, 1'b0, 0);
        nw(1049, 767);
        wr(101, 767, 19'h5FE36, P_PIX, 1'b0, 0);
        wr(1051, 766, 19'h5FE01, P_PIX, 1'b0, 0);
        nw(101, 770);
        nw(103, 790);
        idle(8);

        // Sobel requested mid-frame: still PASS until frame start
        so_switch = 1'b1;
        wr(101, 5, 19'h00A36, P_PIX, 1'b0, 0);
        frame_start_seq();

        mag_in = {8'h3F, 8'h40};
        wr(101, 5, 19'h00A36, 36'h00003FFFF, 1'b1, 1);
        wr(103, 5, 19'h00A37, 36'h00003FFFF, 1'b1, 1);
        idle(8);
        mag_in = {8'hFF, 8'h00};
        wr(105, 5, 19'h00A38, 36'hFFFFC0000, 1'b1, 1);
        idle(8);
        mag_in = {8'h10, 8'h3F};
        wr(107, 5, 19'h00A39, 36'h000000000, 1'b0, 0);
        idle(8);
        thresh = 8'h00;
        mag_in = 16'h0000;
        wr(109, 5, 19'h00A3A, 36'hFFFFFFFFF, 1'b1, 2);
        idle(8);
        thresh = 8'h40;

        // Grayscale
        so_switch = 1'b0;
        gs_switch = 1'b1;
        frame_start_seq();
        pix_in = G_PIX;
        wr(101, 5, 19'h00A36, G_WORD, 1'b0, 0);
        idle(8);

        // Mid-frame reset with Sobel requested: back to PASS until frame start
        so_switch = 1'b1;
        gs_switch = 1'b0;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        exp_edges = 0;
        wr(101, 5, 19'h00A36, G_PIX, 1'b0, 0);
        frame_start_seq();
        mag_in = {8'h3F, 8'h40};
        wr(101, 5, 19'h00A36, 36'h00003FFFF, 1'b1, 1);
        frame_start_seq();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
